// File: rtl/result_streamer.sv
// Streams a contiguous range of result BRAM words onto an AXI-Stream output.
// A 2-entry buffer absorbs the 1-cycle BRAM read latency and sink backpressure.
module result_streamer #(
    parameter int PE_COUNT   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BRAM_DEPTH = 1024,
    parameter int ADDR_WIDTH = $clog2(BRAM_DEPTH)
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic [ADDR_WIDTH:0]              length,
    output logic                             bram_rd_en,
    output logic [ADDR_WIDTH-1:0]            bram_rd_addr,
    input  logic [PE_COUNT*DATA_WIDTH-1:0]   bram_rd_dout,
    output logic [PE_COUNT*DATA_WIDTH-1:0]   m_tdata,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic                             m_tlast,
    output logic                             busy,
    output logic                             done
);

    localparam int W = PE_COUNT * DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issued;
    logic [ADDR_WIDTH:0]   sent;
    logic                  inflight;
    logic [W-1:0]          fifo_mem [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            fifo_count;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [2:0]            occupancy;

    // A read is only issued when the buffer is guaranteed a free slot on its return.
    always_comb begin
        m_tvalid  = (fifo_count != 2'd0);
        pop       = m_tvalid & m_tready;
        push      = inflight;
        occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
        issue     = (state == RUN) && (issued < len_q) && (occupancy < 3'd2);
    end

    always_comb begin
        bram_rd_en   = issue;
        bram_rd_addr = issue ? (base_q + issued[ADDR_WIDTH-1:0]) : '0;
        m_tdata      = m_tvalid ? fifo_mem[rd_ptr] : '0;
        m_tlast      = m_tvalid && (sent == (len_q - ONE));
        busy         = (state != IDLE);
        done         = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issued      <= '0;
            sent        <= '0;
            inflight    <= 1'b0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            fifo_count  <= '0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            inflight   <= issue;
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
            if (push) begin
                fifo_mem[wr_ptr] <= bram_rd_dout;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                sent   <= sent + ONE;
            end
            if (issue) begin
                issued <= issued + ONE;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        len_q  <= length;
                        issued <= '0;
                        sent   <= '0;
                        state  <= (length == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (pop && m_tlast) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/result_streamer.md
# result_streamer

Drains a contiguous range of result BRAM words onto an AXI-Stream-style output once the SIMD datapath finishes a program. Sits directly downstream of the datapath: it uses the result BRAM's second (read) port while the datapath owns the write port, and is normally started by the datapath's `out_data_valid` pulse. Each stream beat carries one full BRAM word (all PE lanes). Internal 2-entry buffer absorbs the 1-cycle BRAM read latency and sink backpressure without losing or duplicating words.

## Interface
- `PE_COUNT`, 4: lanes per BRAM word.
- `DATA_WIDTH`, 32: bits per lane.
- `BRAM_DEPTH`, 1024: result BRAM words.
- `ADDR_WIDTH`, $clog2(BRAM_DEPTH): BRAM address width.

- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin transfer; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first word address; latched on accepted start.
- `length`  in  ADDR_WIDTH+1  words to send, 0..BRAM_DEPTH; latched on accepted start.
- `bram_rd_en`  out  1  result BRAM read enable.
- `bram_rd_addr`  out  ADDR_WIDTH  result BRAM read address.
- `bram_rd_dout`  in  PE_COUNT×DATA_WIDTH  read data, valid the cycle after `bram_rd_en`.
- `m_tdata`  out  PE_COUNT×DATA_WIDTH  stream payload.
- `m_tvalid`  out  1  payload valid.
- `m_tready`  in  1  sink ready.
- `m_tlast`  out  1  final beat of transfer.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: on `start`=1 latch `base_addr`, `length`; zero issue and send counters; go RUN if length≠0, else DONE.
- RUN: issue read `base_addr+issued` (mod BRAM_DEPTH, natural ADDR_WIDTH wrap) when issued<length and (fifo_count + inflight − pop) < 2, where pop = `m_tvalid & m_tready`. At most one read in flight per cycle; inflight clears when data is written to the buffer.
- Buffer: 2-entry FIFO; head drives `m_tdata`; `m_tvalid` = fifo_count≠0. Push and pop in the same cycle allowed.
- `m_tlast` = `m_tvalid` and head is beat index length−1.
- Beat handshake `m_tvalid & m_tready`: pop head, increment send counter. Handshake with `m_tlast` → DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `busy` = state≠IDLE.
- `start` while busy: ignored, no effect on latched values.
- AXIS rules: once `m_tvalid` rises, `m_tdata`/`m_tlast` stay stable and `m_tvalid` stays high until handshake. `m_tvalid` never depends combinationally on `m_tready`.
- length=BRAM_DEPTH: every word sent once, addresses wrap back to base−1.

## Timing
- Reset (rstn=0 at clock edge): state IDLE, FIFO emptied, counters and inflight cleared; `bram_rd_en`=0, `bram_rd_addr`=0, `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `busy`=0, `done`=0. Applies mid-transfer: transfer abandoned, no `done`.
- `start` sampled at edge E0 → `busy` and first `bram_rd_en` high in cycle after E0; data captured at E2; `m_tvalid` first high 2 cycles after E0.
- With `m_tready` held high: one beat per cycle, no bubbles; length N → last handshake N+1 cycles after E0; `done` high the cycle after last handshake; IDLE the cycle after that.
- length=0: DONE the cycle after E0, `done` pulse, no reads, no beats.
- Next `start` accepted the first cycle back in IDLE (i.e. cycle after `done`).
- `m_tready` low: reads stall once buffer+inflight reach 2; no read issued without guaranteed buffer space.

## Test plan
- base 0, length 4, words 0x10..0x13 (all lanes), `m_tready`=1 → reads 0,1,2,3 on consecutive cycles; beats 0x10..0x13 on consecutive cycles from 2 cycles after start; `m_tlast` on 0x13 only; `done` 1 cycle after.
- base 8, length 6, `m_tready` pattern 1,0,0,1,0,1,1,… → exactly 6 beats in order 8..13, payload stable during stalls, no more than 2 reads outstanding beyond accepted beats.
- base 1022, length 4 → read addresses 1022,1023,0,1; four beats, `m_tlast` on 4th.
- length 0 → `done` pulse cycle after start, `m_tvalid` and `bram_rd_en` never high; `start` pulsed while busy on a length-8 run → only 8 beats, single `done`.
- rstn low during beat 3 of length 10 → next cycle all outputs 0, IDLE; new start base 0 length 2 → exactly 2 fresh beats, correct `m_tlast`.
- length 1024, `m_tready` random 50% → 1024 beats, every address once starting at base, single `m_tlast`, single `done`.
